// File: rtl/mem_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_rd_arbiter_if
// Bundles the shared memory read channel as seen by the arbiter: the I-cache
// and D-cache request/response ports plus the single memory-side channel.
//
// Signals (directions given for the slave modport, i.e. the arbiter):
//   ic_rd_req_valid/addr      in   I-cache burst request
//   ic_rd_req_ready           out  request accepted by arbiter+memory
//   ic_rd_rsp_valid/data/last out  response beats to I-cache
//   ic_rd_rsp_ready           in   I-cache accepts beat
//   dc_*                           same set for the D-cache
//   to_mem_rd_req_valid/addr  out  burst request to memory
//   from_mem_rd_req_ready     in   memory accepts request
//   from_mem_rd_rsp_*         in   memory beat valid/data/last
//   to_mem_rd_rsp_ready       out  beat accepted
//
// Modports: slave = arbiter side, master = surrounding caches + memory.
// ---------------------------------------------------------------------------
interface mem_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ic_rd_req_valid;
  logic [ADDR_W-1:0] ic_rd_req_addr;
  logic              ic_rd_req_ready;
  logic              ic_rd_rsp_valid;
  logic [DATA_W-1:0] ic_rd_rsp_data;
  logic              ic_rd_rsp_last;
  logic              ic_rd_rsp_ready;

  logic              dc_rd_req_valid;
  logic [ADDR_W-1:0] dc_rd_req_addr;
  logic              dc_rd_req_ready;
  logic              dc_rd_rsp_valid;
  logic [DATA_W-1:0] dc_rd_rsp_data;
  logic              dc_rd_rsp_last;
  logic              dc_rd_rsp_ready;

  logic              to_mem_rd_req_valid;
  logic [ADDR_W-1:0] to_mem_rd_req_addr;
  logic              from_mem_rd_req_ready;
  logic              from_mem_rd_rsp_valid;
  logic [DATA_W-1:0] from_mem_rd_rsp_data;
  logic              from_mem_rd_rsp_last;
  logic              to_mem_rd_rsp_ready;

  modport slave (
    input  ic_rd_req_valid, ic_rd_req_addr, ic_rd_rsp_ready,
    input  dc_rd_req_valid, dc_rd_req_addr, dc_rd_rsp_ready,
    input  from_mem_rd_req_ready, from_mem_rd_rsp_valid,
    input  from_mem_rd_rsp_data, from_mem_rd_rsp_last,
    output ic_rd_req_ready, ic_rd_rsp_valid, ic_rd_rsp_data, ic_rd_rsp_last,
    output dc_rd_req_ready, dc_rd_rsp_valid, dc_rd_rsp_data, dc_rd_rsp_last,
    output to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );

  modport master (
    output ic_rd_req_valid, ic_rd_req_addr, ic_rd_rsp_ready,
    output dc_rd_req_valid, dc_rd_req_addr, dc_rd_rsp_ready,
    output from_mem_rd_req_ready, from_mem_rd_rsp_valid,
    output from_mem_rd_rsp_data, from_mem_rd_rsp_last,
    input  ic_rd_req_ready, ic_rd_rsp_valid, ic_rd_rsp_data, ic_rd_rsp_last,
    input  dc_rd_req_ready, dc_rd_rsp_valid, dc_rd_rsp_data, dc_rd_rsp_last,
    input  to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rd_arbiter
// Shares one memory read channel (burst request + response beats) between
// the I-cache (port 0) and the D-cache (port 1). One requester owns the
// channel per burst: its address goes to memory and response beats are
// routed back to it only; the channel is released after the last beat.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   bus       if   mem_rd_arbiter_if.slave (cache ports + memory channel)
//   grant     out  current owner (0=I-cache, 1=D-cache), valid when busy
//   busy      out  transaction in flight (REQ or RESP)
//   beat_cnt  out  beats accepted in current burst, saturating
//
// Optional feature macro: MEM_RD_ARB_RR_EN
//   defined   -> round-robin on ties using a last_grant register
//   undefined -> fixed priority, D-cache wins ties
// ---------------------------------------------------------------------------
module mem_rd_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BEAT_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_rd_arbiter_if.slave       bus,
  output logic                  grant,
  output logic                  busy,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    RESP = 3'b100
  } state_t;

  state_t            state;
  logic              req_vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              win;
  logic              req_phase;
  logic              rsp_phase;
  logic              ic_sel;
  logic              dc_sel;
  logic              beat_hs;

  function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef MEM_RD_ARB_RR_EN
  logic last_grant;
  // On a tie the port that was not served last wins.
  assign win = (bus.ic_rd_req_valid && bus.dc_rd_req_valid) ? ~last_grant
                                                            : bus.dc_rd_req_valid;
`else
  assign win = bus.dc_rd_req_valid;
`endif

  // Gating with rst keeps every valid/ready low in the reset cycle, so a
  // reset landing mid-burst never forwards or accepts a beat.
  assign req_phase = req_vld_p0 && !rst;
  assign rsp_phase = (state == RESP) && !rst;
  assign ic_sel    = rsp_phase && !grant;
  assign dc_sel    = rsp_phase && grant;

  assign bus.to_mem_rd_req_valid = req_phase;
  assign bus.to_mem_rd_req_addr  = addr_p0;
  assign bus.ic_rd_req_ready     = req_phase && !grant && bus.from_mem_rd_req_ready;
  assign bus.dc_rd_req_ready     = req_phase && grant && bus.from_mem_rd_req_ready;

  assign bus.ic_rd_rsp_valid = ic_sel && bus.from_mem_rd_rsp_valid;
  assign bus.ic_rd_rsp_data  = ic_sel ? bus.from_mem_rd_rsp_data : {DATA_W{1'b0}};
  assign bus.ic_rd_rsp_last  = ic_sel && bus.from_mem_rd_rsp_last;
  assign bus.dc_rd_rsp_valid = dc_sel && bus.from_mem_rd_rsp_valid;
  assign bus.dc_rd_rsp_data  = dc_sel ? bus.from_mem_rd_rsp_data : {DATA_W{1'b0}};
  assign bus.dc_rd_rsp_last  = dc_sel && bus.from_mem_rd_rsp_last;

  assign bus.to_mem_rd_rsp_ready = (ic_sel && bus.ic_rd_rsp_ready) ||
                                   (dc_sel && bus.dc_rd_rsp_ready);
  assign beat_hs = bus.from_mem_rd_rsp_valid && bus.to_mem_rd_rsp_ready;

  // Stage p0: arbitration decision, address capture and burst tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      busy       <= 1'b0;
      req_vld_p0 <= 1'b0;
      beat_cnt   <= '0;
      addr_p0    <= '0;
`ifdef MEM_RD_ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ic_rd_req_valid || bus.dc_rd_req_valid) begin
            grant      <= win;
            addr_p0    <= win ? bus.dc_rd_req_addr : bus.ic_rd_req_addr;
            busy       <= 1'b1;
            req_vld_p0 <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.from_mem_rd_req_ready) begin
            req_vld_p0 <= 1'b0;
            beat_cnt   <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (beat_hs) begin
            beat_cnt <= sat_inc(beat_cnt);
            if (bus.from_mem_rd_rsp_last) begin
              busy  <= 1'b0;
              state <= IDLE;
`ifdef MEM_RD_ARB_RR_EN
              last_grant <= grant;
`endif
            end
          end
        end
        default: begin
          // Illegal one-hot encoding: drop any in-flight transaction.
          busy       <= 1'b0;
          req_vld_p0 <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_rd_arbiter
// Directed testbench for mem_rd_arbiter: reset state, single I-cache burst,
// simultaneous requests, repeated contention, memory request stall, response
// back-pressure and reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_mem_rd_arbiter;

  logic       clk;
  logic       rst;
  logic       grant;
  logic       busy;
  logic [3:0] beat_cnt;

  int checks;
  int failures;

  logic        o_ic_v, o_ic_l, o_dc_v, o_dc_l, o_mem_rdy;
  logic [31:0] o_ic_d, o_dc_d;

  mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_rd_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .BEAT_CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant(grant),
    .busy(busy),
    .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ic_rd_req_valid       = 1'b0;
    bus.ic_rd_req_addr        = '0;
    bus.ic_rd_rsp_ready       = 1'b0;
    bus.dc_rd_req_valid       = 1'b0;
    bus.dc_rd_req_addr        = '0;
    bus.dc_rd_rsp_ready       = 1'b0;
    bus.from_mem_rd_req_ready = 1'b0;
    bus.from_mem_rd_rsp_valid = 1'b0;
    bus.from_mem_rd_rsp_data  = '0;
    bus.from_mem_rd_rsp_last  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive one memory beat for a cycle and capture what both caches observe.
  task automatic send_beat(input logic [31:0] d, input logic l);
    bus.from_mem_rd_rsp_valid = 1'b1;
    bus.from_mem_rd_rsp_data  = d;
    bus.from_mem_rd_rsp_last  = l;
    #1;
    o_ic_v    = bus.ic_rd_rsp_valid;
    o_ic_d    = bus.ic_rd_rsp_data;
    o_ic_l    = bus.ic_rd_rsp_last;
    o_dc_v    = bus.dc_rd_rsp_valid;
    o_dc_d    = bus.dc_rd_rsp_data;
    o_dc_l    = bus.dc_rd_rsp_last;
    o_mem_rdy = bus.to_mem_rd_rsp_ready;
    tick();
    bus.from_mem_rd_rsp_valid = 1'b0;
    bus.from_mem_rd_rsp_data  = '0;
    bus.from_mem_rd_rsp_last  = 1'b0;
  endtask

  // Memory accepts the pending request in this cycle.
  task automatic mem_accept();
    bus.from_mem_rd_req_ready = 1'b1;
    tick();
    bus.from_mem_rd_req_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.ic_rd_req_valid       = 1'b1;
    bus.dc_rd_req_valid       = 1'b1;
    bus.from_mem_rd_req_ready = 1'b1;
    bus.from_mem_rd_rsp_valid = 1'b1;
    bus.ic_rd_rsp_ready       = 1'b1;
    bus.dc_rd_rsp_ready       = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({busy, grant, beat_cnt} !== 6'b0) begin
      failures++;
      $display("FAIL reset_status got busy=%0b grant=%0b cnt=%0d exp 0/0/0", busy, grant, beat_cnt);
    end
    checks++;
    if ({bus.to_mem_rd_req_valid, bus.ic_rd_req_ready, bus.dc_rd_req_ready,
         bus.ic_rd_rsp_valid, bus.dc_rd_rsp_valid, bus.to_mem_rd_rsp_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_handshakes got %b exp 000000",
               {bus.to_mem_rd_req_valid, bus.ic_rd_req_ready, bus.dc_rd_req_ready,
                bus.ic_rd_rsp_valid, bus.dc_rd_rsp_valid, bus.to_mem_rd_rsp_ready});
    end
    checks++;
    if (bus.to_mem_rd_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr got %h exp 00000000", bus.to_mem_rd_req_addr);
    end
    // Out of reset, memory rsp_valid in IDLE must be ignored.
    clear_inputs();
    rst = 1'b0;
    bus.from_mem_rd_rsp_valid = 1'b1;
    bus.ic_rd_rsp_ready       = 1'b1;
    #1;
    checks++;
    if ({bus.to_mem_rd_rsp_ready, bus.ic_rd_rsp_valid, bus.dc_rd_rsp_valid} !== 3'b0) begin
      failures++;
      $display("FAIL idle_rsp_ignored got %b exp 000",
               {bus.to_mem_rd_rsp_ready, bus.ic_rd_rsp_valid, bus.dc_rd_rsp_valid});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_single_ic();
    do_reset();
    bus.ic_rd_req_valid = 1'b1;
    bus.ic_rd_req_addr  = 32'h0000_1020;
    bus.from_mem_rd_req_ready = 1'b1;
    #1;
    checks++;
    if ({bus.ic_rd_req_ready, bus.to_mem_rd_req_valid, busy} !== 3'b0) begin
      failures++;
      $display("FAIL ic_idle_no_accept got rdy/val/busy=%b exp 000",
               {bus.ic_rd_req_ready, bus.to_mem_rd_req_valid, busy});
    end
    bus.from_mem_rd_req_ready = 1'b0;
    tick();
    checks++;
    if ({busy, grant, bus.to_mem_rd_req_valid} !== 3'b101 || bus.to_mem_rd_req_addr !== 32'h0000_1020) begin
      failures++;
      $display("FAIL ic_req got busy/grant/val=%b addr=%h exp 101 00001020",
               {busy, grant, bus.to_mem_rd_req_valid}, bus.to_mem_rd_req_addr);
    end
    checks++;
    if (bus.ic_rd_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL ic_ready_no_mem got %b exp 0", bus.ic_rd_req_ready);
    end
    bus.from_mem_rd_req_ready = 1'b1;
    #1;
    checks++;
    if ({bus.ic_rd_req_ready, bus.dc_rd_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL ic_ready_with_mem got ic/dc=%b exp 10", {bus.ic_rd_req_ready, bus.dc_rd_req_ready});
    end
    tick();
    bus.from_mem_rd_req_ready = 1'b0;
    bus.ic_rd_req_valid = 1'b0;
    bus.ic_rd_rsp_ready = 1'b1;
    bus.dc_rd_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat(32'hA0 + i, (i == 7));
      checks++;
      if (o_ic_v !== 1'b1 || o_ic_d !== 32'hA0 + i || o_ic_l !== (i == 7) || o_mem_rdy !== 1'b1) begin
        failures++;
        $display("FAIL ic_beat%0d got v=%b d=%h l=%b rdy=%b exp 1 %h %b 1",
                 i, o_ic_v, o_ic_d, o_ic_l, o_mem_rdy, 32'hA0 + i, (i == 7));
      end
      checks++;
      if ({o_dc_v, o_dc_l} !== 2'b0 || o_dc_d !== 32'h0) begin
        failures++;
        $display("FAIL ic_beat%0d_dc_leak got v=%b d=%h l=%b exp 0 0 0", i, o_dc_v, o_dc_d, o_dc_l);
      end
    end
    checks++;
    if (busy !== 1'b0 || beat_cnt !== 4'd8) begin
      failures++;
      $display("FAIL ic_done got busy=%b cnt=%0d exp 0 8", busy, beat_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_tie_priority();
    do_reset();
    bus.ic_rd_req_valid = 1'b1;
    bus.ic_rd_req_addr  = 32'h100;
    bus.dc_rd_req_valid = 1'b1;
    bus.dc_rd_req_addr  = 32'h200;
    bus.ic_rd_rsp_ready = 1'b1;
    bus.dc_rd_rsp_ready = 1'b1;
    tick();
    bus.from_mem_rd_req_ready = 1'b1;
    #1;
    checks++;
    if (grant !== 1'b1 || bus.to_mem_rd_req_addr !== 32'h200 ||
        {bus.ic_rd_req_ready, bus.dc_rd_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL tie_first got grant=%b addr=%h ic/dc rdy=%b exp 1 00000200 01",
               grant, bus.to_mem_rd_req_addr, {bus.ic_rd_req_ready, bus.dc_rd_req_ready});
    end
    tick();
    bus.from_mem_rd_req_ready = 1'b0;
    bus.dc_rd_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(32'hB0 + i, (i == 3));
      checks++;
      if (o_dc_v !== 1'b1 || o_dc_d !== 32'hB0 + i || o_ic_v !== 1'b0) begin
        failures++;
        $display("FAIL tie_dc_beat%0d got dc v=%b d=%h ic v=%b exp 1 %h 0",
                 i, o_dc_v, o_dc_d, o_ic_v, 32'hB0 + i);
      end
    end
    // One IDLE cycle before the waiting I-cache is granted.
    checks++;
    if (busy !== 1'b0 || bus.to_mem_rd_req_valid !== 1'b0 || bus.ic_rd_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL tie_gap got busy=%b val=%b ic_rdy=%b exp 0 0 0",
               busy, bus.to_mem_rd_req_valid, bus.ic_rd_req_ready);
    end
    tick();
    checks++;
    if (grant !== 1'b0 || busy !== 1'b1 || bus.to_mem_rd_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL tie_second got grant=%b busy=%b addr=%h exp 0 1 00000100",
               grant, busy, bus.to_mem_rd_req_addr);
    end
    mem_accept();
    bus.ic_rd_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_beat(32'hC0 + i, (i == 1));
      checks++;
      if (o_ic_v !== 1'b1 || o_ic_d !== 32'hC0 + i || o_dc_v !== 1'b0) begin
        failures++;
        $display("FAIL tie_ic_beat%0d got ic v=%b d=%h dc v=%b exp 1 %h 0",
                 i, o_ic_v, o_ic_d, o_dc_v, 32'hC0 + i);
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic exp_g;
    do_reset();
    bus.ic_rd_req_valid = 1'b1;
    bus.ic_rd_req_addr  = 32'h100;
    bus.dc_rd_req_valid = 1'b1;
    bus.dc_rd_req_addr  = 32'h200;
    bus.ic_rd_rsp_ready = 1'b1;
    bus.dc_rd_rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
`ifdef MEM_RD_ARB_RR_EN
      exp_g = (k % 2 == 0);
`else
      exp_g = 1'b1;
`endif
      checks++;
      if (grant !== exp_g || busy !== 1'b1 ||
          bus.to_mem_rd_req_addr !== (exp_g ? 32'h200 : 32'h100)) begin
        failures++;
        $display("FAIL b2b_grant%0d got grant=%b busy=%b addr=%h exp %b 1 %h",
                 k, grant, busy, bus.to_mem_rd_req_addr, exp_g, (exp_g ? 32'h200 : 32'h100));
      end
      mem_accept();
      send_beat(32'hD0 + k, 1'b1);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_mem_stall();
    do_reset();
    bus.dc_rd_req_valid = 1'b1;
    bus.dc_rd_req_addr  = 32'h300;
    bus.dc_rd_rsp_ready = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.dc_rd_req_ready !== 1'b0 || bus.ic_rd_req_ready !== 1'b0 ||
          bus.to_mem_rd_req_valid !== 1'b1 || bus.to_mem_rd_req_addr !== 32'h300) begin
        failures++;
        $display("FAIL stall_c%0d got dc_rdy=%b ic_rdy=%b val=%b addr=%h exp 0 0 1 00000300",
                 c, bus.dc_rd_req_ready, bus.ic_rd_req_ready, bus.to_mem_rd_req_valid,
                 bus.to_mem_rd_req_addr);
      end
      tick();
    end
    bus.from_mem_rd_req_ready = 1'b1;
    #1;
    checks++;
    if (bus.dc_rd_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_accept got dc_rdy=%b exp 1", bus.dc_rd_req_ready);
    end
    tick();
    bus.from_mem_rd_req_ready = 1'b0;
    bus.dc_rd_req_valid = 1'b0;
    checks++;
    if (bus.to_mem_rd_req_valid !== 1'b0 || busy !== 1'b1 || beat_cnt !== 4'd0) begin
      failures++;
      $display("FAIL stall_resp got val=%b busy=%b cnt=%0d exp 0 1 0",
               bus.to_mem_rd_req_valid, busy, beat_cnt);
    end
    send_beat(32'hE0, 1'b1);
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.ic_rd_req_valid = 1'b1;
    bus.ic_rd_req_addr  = 32'h400;
    bus.ic_rd_rsp_ready = 1'b1;
    tick();
    mem_accept();
    bus.ic_rd_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(32'hF0 + i, 1'b0);
    bus.ic_rd_rsp_ready = 1'b0;
    bus.from_mem_rd_rsp_valid = 1'b1;
    bus.from_mem_rd_rsp_data  = 32'hF3;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.to_mem_rd_rsp_ready !== 1'b0 || beat_cnt !== 4'd3 ||
          bus.dc_rd_rsp_valid !== 1'b0 || bus.ic_rd_rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d got mem_rdy=%b cnt=%0d dc_v=%b ic_v=%b exp 0 3 0 1",
                 c, bus.to_mem_rd_rsp_ready, beat_cnt, bus.dc_rd_rsp_valid, bus.ic_rd_rsp_valid);
      end
      tick();
    end
    bus.ic_rd_rsp_ready = 1'b1;
    for (int i = 3; i < 8; i++) send_beat(32'hF0 + i, (i == 7));
    checks++;
    if (beat_cnt !== 4'd8 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_done got cnt=%0d busy=%b exp 8 0", beat_cnt, busy);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.ic_rd_req_valid = 1'b1;
    bus.ic_rd_req_addr  = 32'h500;
    bus.ic_rd_rsp_ready = 1'b1;
    tick();
    mem_accept();
    bus.ic_rd_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(32'h50 + i, 1'b0);
    rst = 1'b1;
    bus.from_mem_rd_rsp_valid = 1'b1;
    bus.from_mem_rd_rsp_data  = 32'h53;
    #1;
    checks++;
    if (bus.ic_rd_rsp_valid !== 1'b0 || bus.to_mem_rd_rsp_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_fwd got ic_v=%b mem_rdy=%b exp 0 0",
               bus.ic_rd_rsp_valid, bus.to_mem_rd_rsp_ready);
    end
    tick();
    rst = 1'b0;
    bus.from_mem_rd_rsp_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || beat_cnt !== 4'd0 ||
        {bus.to_mem_rd_req_valid, bus.ic_rd_req_ready, bus.dc_rd_req_ready,
         bus.ic_rd_rsp_valid, bus.dc_rd_rsp_valid, bus.to_mem_rd_rsp_ready} !== 6'b0) begin
      failures++;
      $display("FAIL rstmid_idle got busy=%b cnt=%0d hs=%b exp 0 0 000000", busy, beat_cnt,
               {bus.to_mem_rd_req_valid, bus.ic_rd_req_ready, bus.dc_rd_req_ready,
                bus.ic_rd_rsp_valid, bus.dc_rd_rsp_valid, bus.to_mem_rd_rsp_ready});
    end
    bus.dc_rd_req_valid = 1'b1;
    bus.dc_rd_req_addr  = 32'h600;
    bus.dc_rd_rsp_ready = 1'b1;
    tick();
    checks++;
    if (grant !== 1'b1 || busy !== 1'b1 || bus.to_mem_rd_req_addr !== 32'h600) begin
      failures++;
      $display("FAIL rstmid_new_req got grant=%b busy=%b addr=%h exp 1 1 00000600",
               grant, busy, bus.to_mem_rd_req_addr);
    end
    mem_accept();
    bus.dc_rd_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_beat(32'h60 + i, (i == 1));
      checks++;
      if (o_dc_v !== 1'b1 || o_dc_d !== 32'h60 + i || o_ic_v !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_beat%0d got dc v=%b d=%h ic v=%b exp 1 %h 0",
                 i, o_dc_v, o_dc_d, o_ic_v, 32'h60 + i);
      end
    end
    checks++;
    if (busy !== 1'b0 || beat_cnt !== 4'd2) begin
      failures++;
      $display("FAIL rstmid_done got busy=%b cnt=%0d exp 0 2", busy, beat_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_single_ic();
    test_tie_priority();
    test_back_to_back();
    test_mem_stall();
    test_backpressure();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares the single memory read channel (burst request plus beat responses) between the I-cache (port 0) and the D-cache (port 1).
- Grants one requester per burst transaction.
  - Forwards that requester's address to memory.
  - Routes response beats back to the granted requester only.
  - Releases the channel after the last beat.
- Sits between both cache tops and the memory bus interface.

Parameters:
ADDR_W, 32, request address width (32-byte aligned addresses passed through unmodified)
DATA_W, 32, width of one response beat
BEAT_CNT_W, 4, width of per-burst beat counter (debug/status output)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ic_rd_req_valid  in  1  I-cache read request valid
ic_rd_req_addr  in  ADDR_W  I-cache request address
ic_rd_req_ready  out  1  request accepted by arbiter+memory
ic_rd_rsp_valid  out  1  beat valid to I-cache
ic_rd_rsp_data  out  DATA_W  beat data to I-cache
ic_rd_rsp_last  out  1  last beat to I-cache
ic_rd_rsp_ready  in  1  I-cache accepts beat
dc_rd_req_valid / dc_rd_req_addr / dc_rd_req_ready  same as ic_*, D-cache side
dc_rd_rsp_valid / dc_rd_rsp_data / dc_rd_rsp_last / dc_rd_rsp_ready  same as ic_*, D-cache side
to_mem_rd_req_valid  out  1  request valid to memory
to_mem_rd_req_addr  out  ADDR_W  request address to memory
from_mem_rd_req_ready  in  1  memory accepts request
from_mem_rd_rsp_valid  in  1  memory beat valid
from_mem_rd_rsp_data  in  DATA_W  memory beat data
from_mem_rd_rsp_last  in  1  memory last beat
to_mem_rd_rsp_ready  out  1  beat accepted
grant  out  1  current owner (0=I-cache, 1=D-cache); valid when busy=1
busy  out  1  transaction in flight
beat_cnt  out  BEAT_CNT_W  beats accepted in current burst

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- State machine, one-hot, 3 states: IDLE, REQ, RESP.
- Reset:
  - state=IDLE; grant=0; busy=0; beat_cnt=0; addr register=0.
  - All valid/ready outputs=0.
  - Reset mid-burst aborts immediately; no beat forwarded in the reset cycle.
- IDLE:
  - No ready or valid outputs asserted.
  - If any *_rd_req_valid, pick the winner (see arbitration), register grant and the winner's address, go to REQ.
  - Decision takes 1 cycle; the request is never accepted in IDLE.
- REQ:
  - to_mem_rd_req_valid=1; to_mem_rd_req_addr=registered address.
  - Winner's *_rd_req_ready = from_mem_rd_req_ready, combinational, same cycle.
  - Loser's ready=0.
  - On from_mem_rd_req_ready=1: go to RESP and clear beat_cnt.
  - The requester must hold valid/addr until ready. A requester dropping valid in REQ does not cancel the memory request.
- RESP:
  - Granted port: *_rd_rsp_valid/data/last = memory signals; to_mem_rd_rsp_ready = granted *_rd_rsp_ready.
  - Other port: rsp_valid=0, last=0, data=0.
  - Each beat handshake (valid&ready) increments beat_cnt; beat_cnt saturates at all-ones and does not wrap.
  - Handshake with last=1: go to IDLE. The new arbitration occurs in the following cycle, so there is no back-to-back grant in the same cycle.
- busy=1 in REQ and RESP. grant is constant from leaving IDLE until returning to IDLE.
- Arbitration (default, fixed priority): D-cache wins whenever both requests are valid in IDLE.
- Simultaneous events: a new request arriving while busy waits, with its ready low, until IDLE. A memory rsp_valid in REQ or IDLE is ignored (to_mem_rd_rsp_ready=0).

Optional Feature:
MEM_RD_ARB_RR_EN:
- Defined: round-robin arbitration. A 1-bit last_grant register (reset 0) is updated on each return to IDLE. On a tie, the port not equal to last_grant wins.
- Undefined: fixed D-cache priority as above, and no last_grant register.

Test Plan:
1. Reset, then I-cache only, addr 0x0000_1020 → grant=0 one cycle later, to_mem addr 0x0000_1020, ic ready high with mem ready; 8 beats 0xA0..0xA7 reach ic_rsp only; beat_cnt=8; busy drops after last.
2. Both request in the same cycle, addr ic=0x100 dc=0x200 → default: dc served first (mem addr 0x200); after its last beat plus 1 IDLE cycle, ic served (0x100).
3. Same as 2 with MEM_RD_ARB_RR_EN, repeated 3 times back-to-back → grants alternate 1,0,1,0,1,0.
4. Memory holds from_mem_rd_req_ready=0 for 5 cycles → requester ready stays 0, to_mem valid and addr stable; accept on cycle 6.
5. Granted cache deasserts rsp_ready on beat 3 for 2 cycles → to_mem_rd_rsp_ready=0, beat_cnt holds at 3, other port's rsp_valid stays 0.
6. Assert rst during beat 4 of a burst → next cycle state IDLE, busy=0, all ready/valid 0; a new dc request is then served normally.
